fifo_ctrl: RTL

//  Pointer/flag controller that drives a 2**ADDRW-entry register-file storage array.
//  - Storage has a synchronous write port and an asynchronous (combinational) read port.
//  - Presents valid/ready push and pop interfaces and generates the storage write and

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ptr.sv | 23 ++
 rtl/fifo_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-flag helpers for the FIFO pointer/flag controller.
// Pointers carry one extra wrap bit above the storage address.
package fifo_pkg;

   localparam int DEF_ADDRW = 2;
   localparam int DEF_DATAW = 2;

   // Pointers are passed zero-extended to 16 bits so one helper serves any ADDRW up to 15.
   // Full means only the wrap bit (bit addrw) differs between the two pointers.
   function automatic logic ptr_full(input logic [15:0] wptr, input logic [15:0] rptr,
                                     input int unsigned addrw);
      return (wptr ^ rptr) == (16'd1 << addrw);
   endfunction

   function automatic logic ptr_empty(input logic [15:0] wptr, input logic [15:0] rptr);
      return wptr == rptr;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: an up-counter that rolls over naturally at 2**W.
// Reset is synchronous and takes priority over the increment.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int W = DEF_ADDRW + 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_ptr
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_ptr <= '0;
      else if (i_inc)
         o_ptr <= o_ptr + ONE;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external register-file storage array
// (synchronous write port, combinational read port) behind valid/ready push/pop ports.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRW = DEF_ADDRW,
   parameter int DATAW = DEF_DATAW
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push_valid,
   output logic             o_push_ready,
   input  logic [DATAW-1:0] i_push_data,
   output logic             o_pop_valid,
   input  logic             i_pop_ready,
   output logic [DATAW-1:0] o_pop_data,
   output logic             o_wen,
   output logic [ADDRW-1:0] o_waddr,
   output logic [DATAW-1:0] o_wdata,
   output logic [ADDRW-1:0] o_raddr,
   input  logic [DATAW-1:0] i_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [ADDRW:0]   o_count
);

   localparam int PTRW = ADDRW + 1;
   localparam logic [PTRW-1:0] ONE = PTRW'(1);

   logic [PTRW-1:0] wptr;
   logic [PTRW-1:0] rptr;
   logic            push_fire;
   logic            pop_fire;

   assign o_full       = ptr_full(16'(wptr), 16'(rptr), ADDRW);
   assign o_empty      = ptr_empty(16'(wptr), 16'(rptr));
   assign o_push_ready = !o_full;
   assign o_pop_valid  = !o_empty;

   // A push while full or a pop while empty never fires, so pointers cannot overrun.
   assign push_fire = i_push_valid & o_push_ready;
   assign pop_fire  = o_pop_valid & i_pop_ready;

   // Reset suppresses the storage write so a flushed FIFO leaves storage untouched.
   assign o_wen      = push_fire & ~i_rst;
   assign o_waddr    = wptr[ADDRW-1:0];
   assign o_wdata    = i_push_data;
   assign o_raddr    = rptr[ADDRW-1:0];
   assign o_pop_data = i_rdata;

   fifo_ptr #(.W(PTRW)) u_wptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (push_fire),
      .o_ptr (wptr)
   );

   fifo_ptr #(.W(PTRW)) u_rptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (pop_fire),
      .o_ptr (rptr)
   );

   // Occupancy tracks wptr - rptr; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_count <= '0;
      else begin
         case ({push_fire, pop_fire})
            2'b10:   o_count <= o_count + ONE;
            2'b01:   o_count <= o_count - ONE;
            default: o_count <= o_count;
         endcase
      end
   end

endmodule
